// File: rtl/servis_rst_pkg.sv
// Shared types and constants for the servis reset sequencer.
// Holds the sequencer state encoding, reset-cause codes and counter sizing helper.
package servis_rst_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        PERIPH_REL = 2'd1,
        CORE_REL   = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;

    // Delay counter width; clamped to 1 so a delay of 1 still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/servis_debounce.sv
// Synchronizer plus debounce counter for a bouncy asynchronous input.
// The output flips only after the synced input disagrees with it for DEBOUNCE_CYCLES cycles.
module servis_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_out
);

    localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_out;
    logic                   w_in_s;

    assign w_in_s = r_sync[SYNC_STAGES-1];
    assign o_out  = r_out;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            if (w_in_s == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_out <= w_in_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/servis_rst_seq.sv
// Reset sequencer: releases peripheral reset, then core reset, after PLL lock.
// Lock loss or a debounced button press aborts to HOLD and records the cause.
module servis_rst_seq
    import servis_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16000,
    parameter int unsigned PERIPH_DELAY    = 256,
    parameter int unsigned CORE_DELAY      = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_locked,
    input  logic       i_btn,
    output logic       o_rst_periph,
    output logic       o_rst_core,
    output logic       o_ready,
    output logic [1:0] o_cause,
    output logic [7:0] o_rst_count
);

    localparam int unsigned      CNT_W       = cnt_width(PERIPH_DELAY, CORE_DELAY);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);

    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic                   w_locked_s;
    logic                   w_btn_db;
    logic                   w_abort;

    state_t                 r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic                   r_rst_periph, w_rst_periph_next;
    logic                   r_rst_core, w_rst_core_next;
    logic [1:0]             r_cause, w_cause_next;
    logic [7:0]             r_rst_count, w_rst_count_next;

    servis_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_in  (i_btn),
        .o_out (w_btn_db)
    );

    assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
    assign w_abort    = ~w_locked_s | w_btn_db;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lock_sync  <= '0;
            r_state      <= HOLD;
            r_cnt        <= '0;
            r_rst_periph <= 1'b1;
            r_rst_core   <= 1'b1;
            r_cause      <= CAUSE_POR;
            r_rst_count  <= '0;
        end else begin
            r_lock_sync  <= {r_lock_sync[SYNC_STAGES-2:0], i_locked};
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_rst_periph <= w_rst_periph_next;
            r_rst_core   <= w_rst_core_next;
            r_cause      <= w_cause_next;
            r_rst_count  <= w_rst_count_next;
        end
    end

    // Abort takes priority over the delay-expired transition in both release states.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            HOLD: begin
                if (w_locked_s && !w_btn_db) begin
                    w_state_next = PERIPH_REL;
                    w_cnt_next   = '0;
                end
            end
            PERIPH_REL: begin
                if (w_abort) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end else if (r_cnt == PERIPH_LAST) begin
                    w_state_next = CORE_REL;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            CORE_REL: begin
                if (w_abort) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end else if (r_cnt == CORE_LAST) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_next = HOLD;
                end
            end
            default: begin
                w_state_next = HOLD;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_rst_periph_next = (w_state_next == HOLD) || (w_state_next == PERIPH_REL);
        w_rst_core_next   = (w_state_next != RUN);
        w_cause_next      = r_cause;
        w_rst_count_next  = r_rst_count;
        if ((r_state != HOLD) && w_abort) begin
            w_cause_next = !w_locked_s ? CAUSE_LOCK : CAUSE_BTN;
            if (r_rst_count != 8'hFF) begin
                w_rst_count_next = r_rst_count + 8'd1;
            end
        end
    end

    assign o_rst_periph = r_rst_periph;
    assign o_rst_core   = r_rst_core;
    assign o_ready      = ~r_rst_core;
    assign o_cause      = r_cause;
    assign o_rst_count  = r_rst_count;

endmodule
